// File: rtl/video_timing_gen.sv
// Raster source with test patterns: hsync/vsync/de and 10-bit RGB, all registered.
// Latency: one clock from (h_cnt, v_cnt) to outputs; no backpressure, i_en=0 parks the raster at its origin.
module video_timing_gen #(
  parameter int HACT  = 10,
  parameter int HFP   = 2,
  parameter int HSW   = 2,
  parameter int HBP   = 2,
  parameter int VACT  = 4,
  parameter int VFP   = 1,
  parameter int VSW   = 1,
  parameter int VBP   = 1,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  input  logic [1:0] i_pattern_sel,
  output logic       o_vsync,
  output logic       o_hsync,
  output logic       o_de,
  output logic [9:0] o_r_data,
  output logic [9:0] o_g_data,
  output logic [9:0] o_b_data
);

  localparam int HTOTAL = HSW + HBP + HACT + HFP;
  localparam int VTOTAL = VSW + VBP + VACT + VFP;
  localparam int HA0    = HSW + HBP;
  localparam int VA0    = VSW + VBP;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [9:0]       frame_cnt_q, frame_cnt_d;
  logic [1:0]       pat_q, pat_d;
  logic             vsync_q, vsync_d, hsync_q, hsync_d, de_q, de_d;
  logic [9:0]       r_q, r_d, g_q, g_d, b_q, b_d;

  logic             h_wrap, v_wrap;
  logic [31:0]      xi, yi;
  logic [9:0]       ramp, chk;

  always_comb begin
    h_wrap      = (h_cnt_q == CNT_W'(HTOTAL - 1));
    v_wrap      = (v_cnt_q == CNT_W'(VTOTAL - 1));
    xi          = 32'(h_cnt_q) - 32'(HA0);
    yi          = 32'(v_cnt_q) - 32'(VA0);
    ramp        = 10'(xi + yi * 32'(HACT));
    chk         = (xi[0] ^ yi[0]) ? 10'h3FF : 10'h000;

    h_cnt_d     = '0;
    v_cnt_d     = '0;
    frame_cnt_d = '0;
    pat_d       = pat_q;
    vsync_d     = 1'b0;
    hsync_d     = 1'b0;
    de_d        = 1'b0;
    r_d         = '0;
    g_d         = '0;
    b_d         = '0;

    if (i_en) begin
      h_cnt_d     = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
      v_cnt_d     = v_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
        if (v_wrap) frame_cnt_d = frame_cnt_q + 10'd1;
      end
      // Pattern only changes at the frame origin so a frame is never mixed.
      if (h_cnt_q == '0 && v_cnt_q == '0) pat_d = i_pattern_sel;

      hsync_d = (32'(h_cnt_q) < 32'(HSW));
      vsync_d = (32'(v_cnt_q) < 32'(VSW));
      de_d    = (32'(h_cnt_q) >= 32'(HA0)) && (32'(h_cnt_q) < 32'(HA0 + HACT)) &&
                (32'(v_cnt_q) >= 32'(VA0)) && (32'(v_cnt_q) < 32'(VA0 + VACT));

      if (de_d) begin
        unique case (pat_q)
          2'd0: begin r_d = ramp;        g_d = ramp;        b_d = ramp;        end
          2'd1: begin r_d = chk;         g_d = chk;         b_d = chk;         end
          2'd2: begin r_d = 10'h3FF;     g_d = 10'h000;     b_d = 10'h000;     end
          default: begin r_d = frame_cnt_q; g_d = frame_cnt_q; b_d = frame_cnt_q; end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      pat_q       <= '0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      de_q        <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      pat_q       <= pat_d;
      vsync_q     <= vsync_d;
      hsync_q     <= hsync_d;
      de_q        <= de_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign o_vsync  = vsync_q;
  assign o_hsync  = hsync_q;
  assign o_de     = de_q;
  assign o_r_data = r_q;
  assign o_g_data = g_q;
  assign o_b_data = b_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen against a position-from-time raster model.
module tb_video_timing_gen;

  localparam int HACT = 10, HFP = 2, HSW = 2, HBP = 2;
  localparam int VACT = 4,  VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HSW + HBP + HACT + HFP;
  localparam int VT = VSW + VBP + VACT + VFP;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       o_vsync, o_hsync, o_de;
  logic [9:0] o_r_data, o_g_data, o_b_data;

  logic       en_s = 1'b0;
  logic [1:0] sel_s = 2'd3;
  logic       vs_s, hs_s, de_s;
  logic [9:0] r_s, g_s, b_s;

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk(clk), .rstn(rstn), .i_en(i_en), .i_pattern_sel(sel),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
    .o_r_data(o_r_data), .o_g_data(o_g_data), .o_b_data(o_b_data)
  );

  // Tiny raster (4x4 clocks per frame) so the 10-bit frame stamp can wrap quickly.
  video_timing_gen #(
    .HACT(1), .HFP(1), .HSW(1), .HBP(1), .VACT(1), .VFP(1), .VSW(1), .VBP(1), .CNT_W(3)
  ) dut_s (
    .clk(clk), .rstn(rstn), .i_en(en_s), .i_pattern_sel(sel_s),
    .o_vsync(vs_s), .o_hsync(hs_s), .o_de(de_s),
    .o_r_data(r_s), .o_g_data(g_s), .o_b_data(b_s)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Reference: raster position is a pure function of enabled edges since the last restart.
  int         t = 0;
  logic [1:0] m_pat = 2'd0;
  logic       e_hs, e_vs, e_de;
  logic [9:0] e_r, e_g, e_b;

  task automatic predict();
    int h, v, f, x, y;
    e_hs = 0; e_vs = 0; e_de = 0; e_r = 0; e_g = 0; e_b = 0;
    if (!i_en) begin
      t = 0;
      return;
    end
    h = t % HT;
    v = (t / HT) % VT;
    f = (t / (HT * VT)) % 1024;
    if (h == 0 && v == 0) m_pat = sel;
    x = h - (HSW + HBP);
    y = v - (VSW + VBP);
    e_hs = (h < HSW);
    e_vs = (v < VSW);
    e_de = (x >= 0) && (x < HACT) && (y >= 0) && (y < VACT);
    if (e_de) begin
      case (m_pat)
        2'd0: begin e_r = 10'((x + y * HACT) % 1024); e_g = e_r; e_b = e_r; end
        2'd1: begin e_r = (((x ^ y) & 1) != 0) ? 10'h3FF : 10'h000; e_g = e_r; e_b = e_r; end
        2'd2: begin e_r = 10'h3FF; e_g = 10'h000; e_b = 10'h000; end
        default: begin e_r = 10'(f); e_g = e_r; e_b = e_r; end
      endcase
    end
    t++;
  endtask

  task automatic check_all(input string tag);
    chk_eq({tag, "_hsync"}, o_hsync, e_hs);
    chk_eq({tag, "_vsync"}, o_vsync, e_vs);
    chk_eq({tag, "_de"},    o_de,    e_de);
    chk_eq({tag, "_r"},     o_r_data, e_r);
    chk_eq({tag, "_g"},     o_g_data, e_g);
    chk_eq({tag, "_b"},     o_b_data, e_b);
  endtask

  task automatic step(input string tag);
    predict();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk_eq({tag, "_hsync"}, o_hsync, 0);
    chk_eq({tag, "_vsync"}, o_vsync, 0);
    chk_eq({tag, "_de"},    o_de,    0);
    chk_eq({tag, "_r"},     o_r_data, 0);
    chk_eq({tag, "_g"},     o_g_data, 0);
    chk_eq({tag, "_b"},     o_b_data, 0);
  endtask

  initial begin
    int first_de, last_de, de_cnt, nf;
    logic [9:0] last_px;

    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    t = 0; m_pat = 2'd0;

    // First frame from (0,0) with ramp: sync, de window and pixel count.
    i_en = 1'b1; sel = 2'd0;
    first_de = 0; last_de = 0; de_cnt = 0; last_px = '0;
    for (int e = 1; e <= HT * VT; e++) begin
      step("frame0");
      if (o_de) begin
        if (first_de == 0) first_de = e;
        last_de = e;
        last_px = o_r_data;
        de_cnt++;
      end
    end
    chk_eq("first_de_edge", first_de, 37);
    chk_eq("last_de_edge", last_de, 94);
    chk_eq("last_px", last_px, 39);
    chk_eq("de_per_frame", de_cnt, 40);

    // Enable drop at edge 50 for 5 clocks, then restart from the origin.
    i_en = 1'b0; step("restart");
    i_en = 1'b1;
    repeat (49) step("pre_drop");
    i_en = 1'b0;
    repeat (5) step("disabled");
    i_en = 1'b1;
    step("reen");
    chk_eq("reen_vsync", o_vsync, 1);
    chk_eq("reen_hsync", o_hsync, 1);
    chk_eq("reen_de", o_de, 0);

    // Frame stamp over three fresh frames.
    i_en = 1'b0; step("restart");
    i_en = 1'b1; sel = 2'd3;
    repeat (3 * HT * VT) step("stamp");

    // Ramp -> solid red switched mid active line; applies from next frame.
    i_en = 1'b0; step("restart");
    i_en = 1'b1; sel = 2'd0;
    repeat (40) step("ramp_pre");
    sel = 2'd2;
    repeat (72 + HT * VT) step("red_switch");

    // Checker frame.
    sel = 2'd1;
    repeat (HT * VT) step("checker");

    // Randomized enable drops, pattern changes, one asynchronous mid-frame reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        i_en = 1'b0;
        repeat ($urandom_range(1, 6)) step("rnd_off");
        i_en = 1'b1;
      end
      if ($urandom_range(0, 39) == 0) sel = 2'($urandom);
      if (i == 2000) begin
        #2;
        rstn = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (3) @(posedge clk);
        #1;
        check_zero("held_rst");
        rstn = 1'b1;
        t = 0; m_pat = 2'd0;
      end
      step("rnd");
    end

    // Frame stamp wrap 1023 -> 0 on the tiny raster (one de pixel per frame).
    i_en = 1'b0;
    en_s = 1'b1;
    nf = 0;
    for (int c = 0; c < 1026 * 16; c++) begin
      @(posedge clk);
      #1;
      if (de_s) begin
        chk_eq("wrap_r", r_s, nf % 1024);
        chk_eq("wrap_g", g_s, nf % 1024);
        chk_eq("wrap_b", b_s, nf % 1024);
        chk_eq("wrap_sync", {vs_s, hs_s}, 0);
        nf++;
      end
    end
    chk_eq("wrap_frames", nf, 1026);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Source stage that sits directly upstream of the line-buffer scaler.
- Generates a complete raster: active-high vsync, hsync and de, plus 10-bit R/G/B test-pattern pixels.
- Default geometry is HACT=10, VACT=4, matching the scaler input resolution, so the scaler is driven on-chip without external video.
- Selectable patterns give deterministic, self-checkable pixel values.

Parameters:
- HACT, 10, active pixels per line
- HFP, 2, horizontal front porch (clocks)
- HSW, 2, hsync width (clocks)
- HBP, 2, horizontal back porch (clocks)
- VACT, 4, active lines per frame
- VFP, 1, vertical front porch (lines)
- VSW, 1, vsync width (lines)
- VBP, 1, vertical back porch (lines)
- CNT_W, 8, width of the h/v counters; must hold HTOTAL-1 and VTOTAL-1

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- i_en  input  1  run enable; low holds the raster at its origin
- i_pattern_sel  input  2  0 ramp, 1 checker, 2 solid red, 3 frame stamp
- o_vsync  output  1  vertical sync, active-high, registered
- o_hsync  output  1  horizontal sync, active-high, registered
- o_de  output  1  data enable, registered
- o_r_data  output  10  red pixel, registered
- o_g_data  output  10  green pixel, registered
- o_b_data  output  10  blue pixel, registered

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rstn). All outputs, counters, pattern register and frame counter reset to 0.
- HTOTAL = HSW+HBP+HACT+HFP (default 16). VTOTAL = VSW+VBP+VACT+VFP (default 7).
- Line order: sync, back porch, active, front porch. Frame order follows the same sequence in lines.
- h_cnt counts 0..HTOTAL-1 and wraps to 0.
- v_cnt increments on h_cnt wrap; it counts 0..VTOTAL-1 and wraps to 0.
- On v_cnt wrap, frame_cnt (10-bit) increments; it wraps 1023->0.
- i_en=0: h_cnt, v_cnt and frame_cnt held at 0; all outputs driven 0 on the next edge.
- i_en=1 on an edge: outputs are loaded with the decode of the current (h_cnt, v_cnt), and the counters advance on that same edge.
  - Latency: exactly one clock from counter state to output.
  - First edge with i_en=1 outputs position (0,0).
- Dropping i_en mid-frame aborts the frame. Counters return to 0. The next enable starts a fresh frame from (0,0) with frame_cnt=0.
- Decode:
  - hsync = h_cnt < HSW
  - vsync = v_cnt < VSW
  - de = h_cnt in [HSW+HBP, HSW+HBP+HACT) AND v_cnt in [VSW+VBP, VSW+VBP+VACT)
- Pixel coordinates: x = h_cnt-(HSW+HBP), y = v_cnt-(VSW+VBP), valid only when de.
- Pattern register latches i_pattern_sel only when h_cnt=0 and v_cnt=0, with i_en=1 or on enable start. Mid-frame changes take effect at the next frame.
- Patterns (10-bit, truncated):
  - 0 ramp: R=G=B = x + y*HACT
  - 1 checker: R=G=B = ((x^y)&1) ? 10'h3FF : 10'h000
  - 2 solid red: R=10'h3FF, G=0, B=0
  - 3 frame stamp: R=G=B = frame_cnt
- o_r_data/o_g_data/o_b_data are forced to 0 whenever o_de=0.

Test Plan:
- Reset mid-frame (rstn low for 3 clocks at arbitrary point) -> all outputs 0 immediately, asynchronously. After release with i_en=1, raster restarts at (0,0).
- i_en=1, sel=0, defaults:
  - o_hsync high on edges 1-2 of each 16-edge line.
  - o_vsync high on edges 1-16.
  - o_de first high on edge 37, pixels 0..9.
  - Last active pixel on edge 94, value 39.
  - Frame period 112 clocks; 40 de cycles per frame.
- sel=1 -> line y=0 pixels alternate 000,3FF,000...; line y=1 starts 3FF.
- sel=3, run 3 frames -> all active pixels of frames 0/1/2 equal 0/1/2. Force frame_cnt to 1023 -> next frame shows 0 (wrap).
- Change sel 0->2 mid-active-line -> current frame stays ramp; next frame all active pixels R=3FF, G=B=0.
- Drop i_en at edge 50 for 5 clocks, then re-raise -> outputs 0 while disabled. First edge after re-enable outputs (0,0) with vsync=hsync=1, de=0. frame_cnt restarts at 0.
